// File: rtl/fetch_sequencer_if.sv
// Handshake/bus bundle between the fetch sequencer and its environment
// (instruction memory, instruction register, execute stage, branch unit).
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              halt;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_data;
    logic              imem_err;
    logic              ir_load;
    logic [31:0]       ir_data;
    logic              exec_valid;
    logic              exec_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              fault;

    modport master (
        input  start, halt, imem_ack, imem_data, imem_err,
               exec_ready, redirect_valid, redirect_pc,
        output imem_req, imem_addr, ir_load, ir_data, exec_valid,
               pc, busy, fault
    );

    modport slave (
        output start, halt, imem_ack, imem_data, imem_err,
               exec_ready, redirect_valid, redirect_pc,
        input  imem_req, imem_addr, ir_load, ir_data, exec_valid,
               pc, busy, fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-side controller: owns the PC, runs the imem req/ack handshake, loads
// the IR and holds it valid for execute; handles redirects, halt and faults.
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}},
    parameter int                PC_INC   = 4,
    parameter int                TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);
    localparam logic [7:0]        TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [31:0]       ir_q, ir_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              req_q, load_q, valid_q, busy_q, fault_q;

    // Next-state and datapath decisions for the fetch sequence
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.halt) begin
                    state_d = ST_REQ;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    if (bus.imem_err) begin
                        state_d = ST_FAULT;
                    end else if (pend_q || bus.redirect_valid) begin
                        // Redirected while in flight: drop the word, refetch at target
                        pc_d    = bus.redirect_valid ? bus.redirect_pc : tgt_q;
                        pend_d  = 1'b0;
                        cnt_d   = 8'd0;
                        state_d = ST_REQ;
                    end else begin
                        ir_d    = bus.imem_data;
                        state_d = ST_LOAD;
                    end
                end else begin
                    if (bus.redirect_valid) begin
                        pend_d = 1'b1;
                        tgt_d  = bus.redirect_pc;
                    end else begin
                        pend_d = pend_q;
                    end
                    if (cnt_q == TO_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    cnt_d   = 8'd0;
                    state_d = ST_REQ;
                end else begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.redirect_valid || bus.exec_ready) begin
                    if (bus.redirect_valid) begin
                        pc_d = bus.redirect_pc;
                    end else begin
                        pc_d = pc_q;
                    end
                    cnt_d   = 8'd0;
                    state_d = bus.halt ? ST_IDLE : ST_REQ;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State, datapath registers and strobes registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RESET;
            tgt_q   <= {ADDR_W{1'b0}};
            ir_q    <= 32'd0;
            cnt_q   <= 8'd0;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            req_q   <= (state_d == ST_REQ);
            load_q  <= (state_d == ST_LOAD);
            valid_q <= (state_d == ST_ISSUE);
            busy_q  <= (state_d == ST_REQ) || (state_d == ST_LOAD) || (state_d == ST_ISSUE);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.ir_load    = load_q;
    assign bus.ir_data    = ir_q;
    assign bus.exec_valid = valid_q;
    assign bus.pc         = pc_q;
    assign bus.busy       = busy_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_fetch_sequencer;

    localparam int TIMEOUT = 15;

    logic clk;
    logic reset;

    fetch_sequencer_if #(.ADDR_W(32)) bus ();

    fetch_sequencer #(
        .ADDR_W(32), .PC_RESET(32'h0), .PC_INC(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          st, hl, ak;
        logic [31:0] dt;
        bit          er, rd, rv;
        logic [31:0] rp;
        bit          req;
        logic [31:0] addr;
        bit          ld;
        logic [31:0] ir;
        bit          ev;
        logic [31:0] pc;
        bit          bsy, flt;
    } vec_t;

    int checks = 0;
    int passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit st, hl, ak, input logic [31:0] dt,
                         input bit er, rd, rv, input logic [31:0] rp);
        bus.start = st; bus.halt = hl; bus.imem_ack = ak; bus.imem_data = dt;
        bus.imem_err = er; bus.exec_ready = rd; bus.redirect_valid = rv; bus.redirect_pc = rp;
    endtask

    task automatic chk(input string nm, input bit req, input logic [31:0] addr, input bit ld,
                       input logic [31:0] ir, input bit ev, input logic [31:0] pc,
                       input bit bsy, input bit flt);
        logic [100:0] got, exp;
        got = {bus.imem_req, bus.imem_addr, bus.ir_load, bus.ir_data, bus.exec_valid,
               bus.pc, bus.busy, bus.fault};
        exp = {req, addr, ld, ir, ev, pc, bsy, flt};
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got req=%b addr=%h ld=%b ir=%h ev=%b pc=%h busy=%b fault=%b; expected req=%b addr=%h ld=%b ir=%h ev=%b pc=%h busy=%b fault=%b",
                      nm, bus.imem_req, bus.imem_addr, bus.ir_load, bus.ir_data, bus.exec_valid,
                      bus.pc, bus.busy, bus.fault, req, addr, ld, ir, ev, pc, bsy, flt);
    endtask

    // Compare current outputs with the row's expectation, then apply its inputs for one cycle
    task automatic row(input vec_t v, input string nm);
        chk(nm, v.req, v.addr, v.ld, v.ir, v.ev, v.pc, v.bsy, v.flt);
        drive(v.st, v.hl, v.ak, v.dt, v.er, v.rd, v.rv, v.rp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Behavioural model: phase of the current instruction's life plus architectural state
    localparam int P_IDLE = 0, P_FETCH = 1, P_LOAD = 2, P_ISSUE = 3, P_FAULT = 4;
    int          m_phase, m_wait;
    bit          m_pend;
    logic [31:0] m_tgt, m_pc, m_ir;

    task automatic model_reset();
        m_phase = P_IDLE; m_wait = 0; m_pend = 1'b0; m_tgt = 32'h0; m_pc = 32'h0; m_ir = 32'h0;
    endtask

    task automatic model_step(input bit st, hl, ak, input logic [31:0] dt,
                              input bit er, rd, rv, input logic [31:0] rp);
        if (m_phase == P_IDLE) begin
            if (st && !hl) begin m_phase = P_FETCH; m_wait = 0; end
        end else if (m_phase == P_FETCH) begin
            if (ak && er) m_phase = P_FAULT;
            else if (ak && (m_pend || rv)) begin
                m_pc = rv ? rp : m_tgt; m_pend = 1'b0; m_wait = 0;
            end else if (ak) begin
                m_ir = dt; m_phase = P_LOAD;
            end else begin
                if (rv) begin m_pend = 1'b1; m_tgt = rp; end
                m_wait = m_wait + 1;
                if (m_wait >= TIMEOUT) m_phase = P_FAULT;
            end
        end else if (m_phase == P_LOAD) begin
            if (rv) begin m_pc = rp; m_phase = P_FETCH; m_wait = 0; end
            else begin m_pc = m_pc + 32'd4; m_phase = P_ISSUE; end
        end else if (m_phase == P_ISSUE) begin
            if (rv) m_pc = rp;
            if (rv || rd) begin m_phase = hl ? P_IDLE : P_FETCH; m_wait = 0; end
        end
    endtask

    vec_t tbl[$];
    vec_t seq[$];

    initial begin
        int n;
        int guard;
        bit st, hl, ak, er, rd, rv;
        logic [31:0] dt, rp;

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        do_reset();

        // ---------------- directed table ----------------
        //              st hl ak dt            er rd rv rp          req addr          ld ir            ev pc            bsy flt
        tbl.push_back('{1, 0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,      1, 32'h0,         0, 32'h0,        0, 32'h0,        1, 0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,      1, 32'h0,         0, 32'h0,        0, 32'h0,        1, 0});
        tbl.push_back('{0, 0, 1, 32'hDEADBEEF, 0, 1, 0, 32'h0,      1, 32'h0,         0, 32'h0,        0, 32'h0,        1, 0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 1, 0, 32'h0,      0, 32'h0,         1, 32'hDEADBEEF, 0, 32'h0,        1, 0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 1, 0, 32'h0,      0, 32'h4,         0, 32'hDEADBEEF, 1, 32'h4,        1, 0});
        tbl.push_back('{0, 0, 1, 32'h11111111, 0, 0, 0, 32'h0,      1, 32'h4,         0, 32'hDEADBEEF, 0, 32'h4,        1, 0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 32'h4,         1, 32'h11111111, 0, 32'h4,        1, 0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{0, 0, 1, 32'h0,    0, 0, 0, 32'h0,      0, 32'h8,         0, 32'h11111111, 1, 32'h8,        1, 0});
        tbl.push_back('{0, 1, 0, 32'h0,        0, 1, 0, 32'h0,      0, 32'h8,         0, 32'h11111111, 1, 32'h8,        1, 0});
        tbl.push_back('{1, 0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 32'h8,         0, 32'h11111111, 0, 32'h8,        0, 0});
        tbl.push_back('{0, 0, 1, 32'h22222222, 0, 0, 0, 32'h0,      1, 32'h8,         0, 32'h11111111, 0, 32'h8,        1, 0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 32'h8,         1, 32'h22222222, 0, 32'h8,        1, 0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 32'h100,    0, 32'hC,         0, 32'h22222222, 1, 32'hC,        1, 0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 32'h200,    1, 32'h100,       0, 32'h22222222, 0, 32'h100,      1, 0});
        tbl.push_back('{0, 0, 1, 32'h33333333, 0, 0, 0, 32'h0,      1, 32'h100,       0, 32'h22222222, 0, 32'h100,      1, 0});
        tbl.push_back('{0, 0, 1, 32'h44444444, 0, 0, 0, 32'h0,      1, 32'h200,       0, 32'h22222222, 0, 32'h200,      1, 0});
        tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 32'h300,    0, 32'h200,       1, 32'h44444444, 0, 32'h200,      1, 0});
        tbl.push_back('{0, 0, 1, 32'h55555555, 0, 0, 1, 32'h400,    1, 32'h300,       0, 32'h44444444, 0, 32'h300,      1, 0});
        tbl.push_back('{0, 0, 1, 32'h66666666, 1, 0, 0, 32'h0,      1, 32'h400,       0, 32'h44444444, 0, 32'h400,      1, 0});
        tbl.push_back('{1, 0, 0, 32'h0,        0, 1, 1, 32'h700,    0, 32'h400,       0, 32'h44444444, 0, 32'h400,      0, 1});
        tbl.push_back('{0, 0, 1, 32'h0,        0, 1, 0, 32'h0,      0, 32'h400,       0, 32'h44444444, 0, 32'h400,      0, 1});
        foreach (tbl[i]) row(tbl[i], $sformatf("table_row%0d", i));

        // ---------------- timeout: exactly TIMEOUT request cycles ----------------
        do_reset();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        guard = 0;
        while (bus.imem_req === 1'b1 && guard < 40) begin
            n++; guard++;
            @(negedge clk);
        end
        checks++;
        if (n == TIMEOUT) passes++;
        else $display("FAIL timeout_cycles: got %0d request cycles, expected %0d", n, TIMEOUT);
        chk("timeout_fault", 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);
        drive(1'b1, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b1, 1'b1, 32'h80);
        repeat (3) @(negedge clk);
        chk("timeout_sticky", 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);

        // ---------------- PC wrap and async reset mid-REQ ----------------
        do_reset();
        seq.push_back('{1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0});
        seq.push_back('{0, 0, 1, 32'hABCD0001, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0});
        seq.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hABCD0001, 0, 32'h0,        1, 0});
        seq.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 32'hFFFFFFFC, 0, 32'h4,        0, 32'hABCD0001, 1, 32'h4,        1, 0});
        seq.push_back('{0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'hABCD0001, 0, 32'hFFFFFFFC, 1, 0});
        seq.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'hCAFEF00D, 0, 32'hFFFFFFFC, 1, 0});
        seq.push_back('{0, 1, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        0, 32'hCAFEF00D, 1, 32'h0,        1, 0});
        seq.push_back('{1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'hCAFEF00D, 0, 32'h0,        0, 0});
        seq.push_back('{0, 0, 1, 32'h12345678, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'hCAFEF00D, 0, 32'h0,        1, 0});
        seq.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h12345678, 0, 32'h0,        1, 0});
        seq.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 32'h500,      0, 32'h4,        0, 32'h12345678, 1, 32'h4,        1, 0});
        seq.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h500,      0, 32'h12345678, 0, 32'h500,      1, 0});
        foreach (seq[i]) row(seq[i], $sformatf("wrap_seq%0d", i));
        #2 reset = 1'b0;
        #1 chk("async_reset", 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("idle_after_reset%0d", i), 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
            @(negedge clk);
        end

        // ---------------- randomized traffic vs behavioural model ----------------
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            chk($sformatf("random_cyc%0d", i), m_phase == P_FETCH, m_pc, m_phase == P_LOAD, m_ir,
                m_phase == P_ISSUE, m_pc,
                (m_phase == P_FETCH) || (m_phase == P_LOAD) || (m_phase == P_ISSUE),
                m_phase == P_FAULT);
            if ((m_phase == P_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
                model_reset();
                @(negedge clk);
                reset = 1'b1;
            end else begin
                st = ($urandom_range(0, 1) == 0);
                hl = ($urandom_range(0, 7) == 0);
                ak = ($urandom_range(0, 2) != 0);
                dt = $urandom();
                er = ($urandom_range(0, 40) == 0);
                rd = ($urandom_range(0, 1) == 0);
                rv = ($urandom_range(0, 7) == 0);
                rp = $urandom();
                drive(st, hl, ak, dt, er, rd, rv, rp);
                model_step(st, hl, ak, dt, er, rd, rv, rp);
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-side controller that sequences the 32-bit instruction register. It owns the program counter and runs a req/ack handshake to instruction memory. It pulses the IR load strobe with the fetched word, then holds the instruction valid until the execute stage accepts it. It also handles branch redirects, halt, and memory fault/timeout.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
PC_RESET, 0, PC value after reset
PC_INC, 4, PC increment per sequential fetch
TIMEOUT, 15, max REQ cycles without ack before fault (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin fetching from current PC (sampled in IDLE)
halt  in  1  stop after current instruction is accepted
imem_req  out  1  memory read request, held until imem_ack
imem_addr  out  ADDR_W  fetch address (= pc while imem_req)
imem_ack  in  1  memory response valid this cycle
imem_data  in  32  fetched instruction word, valid with imem_ack
imem_err  in  1  memory error, qualified by imem_ack
ir_load  out  1  one-cycle load strobe to instruction register
ir_data  out  32  word for IR instruction_in, stable while ir_load
exec_valid  out  1  IR holds an un-consumed instruction
exec_ready  in  1  execute stage accepts IR contents
redirect_valid  in  1  branch/jump taken
redirect_pc  in  ADDR_W  branch target
pc  out  ADDR_W  current program counter
busy  out  1  state not IDLE and not FAULT
fault  out  1  sticky memory error/timeout flag

Behaviour:
- Reset (reset=0, any time, including mid-handshake): state=IDLE, pc=PC_RESET, ir_data=0, timeout count=0, redirect-pending=0. All 1-bit outputs are 0. imem_addr shows pc.
- States: IDLE, REQ, LOAD, ISSUE, FAULT. All are registered; outputs decode from state only.
- IDLE: all strobes are 0. If start=1 and halt=0, go to REQ next cycle. Otherwise stay in IDLE.
- REQ: imem_req=1 and imem_addr=pc, both held stable until ack. The timeout counter increments each cycle without ack.
  - ack=1 and err=0: capture imem_data into ir_data, go to LOAD.
  - ack=1 and err=1: go to FAULT.
  - Count reaches TIMEOUT without ack: go to FAULT. If ack and timeout occur in the same cycle, ack wins.
  - The counter clears on every entry to REQ.
- LOAD: ir_load=1 for exactly one cycle. pc <= pc+PC_INC (wraps modulo 2^ADDR_W). Go to ISSUE.
- ISSUE: exec_valid=1. The IR is valid this cycle because it captured on the edge ending LOAD. exec_valid is held until exec_ready=1.
  - On accept with halt=1: go to IDLE.
  - On accept with halt=0: go to REQ.
  - exec_ready is ignored outside ISSUE.
- Latency: start at cycle 0 → imem_req at cycle 1. ack at cycle k → ir_load at k+1 → exec_valid from k+2. Back-to-back fetch with single-cycle ack and exec_ready=1 takes 3 cycles per instruction.
- Redirect, by state:
  - ISSUE, with or without accept: the instruction is retired. pc <= redirect_pc, go to REQ (halt still honoured → IDLE with pc=redirect_pc).
  - LOAD: redirect beats increment, pc <= redirect_pc. ir_load still pulses, but the state goes to REQ, not ISSUE, so exec_valid is never raised and the word is squashed.
  - REQ: the handshake is never aborted. Set redirect-pending and store redirect_pc. On ack (err=0) discard the data with no ir_load, set pc <= stored target, re-enter REQ next cycle. A later redirect before ack overwrites the stored target. Redirect coincident with ack is treated as pending.
  - IDLE or FAULT: redirect is ignored.
- FAULT: fault=1, imem_req=0, exec_valid=0. The state is sticky and exits only via reset. pc holds the faulting address.
- halt while in REQ or LOAD does not cut the fetch short. It takes effect at the ISSUE accept.

Test Plan:
- Reset release, start=1, ack 2 cycles after req with data 0xDEADBEEF, exec_ready=1 → imem_addr=0, ir_load one cycle with ir_data=0xDEADBEEF, exec_valid one cycle, pc=4, next imem_addr=4.
- exec_ready held 0 for 5 cycles → exec_valid stays 1 and no new imem_req. Then exec_ready=1 with halt=1 → IDLE, busy=0, pc=4.
- ISSUE with redirect_valid=1 and redirect_pc=0x100 → next imem_addr=0x100. Redirect asserted in REQ before ack → no ir_load for the returned word, next request at 0x100.
- ack never arrives with TIMEOUT=15 → fault=1 after exactly 15 REQ cycles, imem_req=0. ack with imem_err=1 → fault next cycle. Both cases stay faulted until reset.
- pc=0xFFFFFFFC sequential fetch → pc wraps to 0x00000000.
- reset=0 asserted mid-REQ → all outputs 0 and pc=PC_RESET immediately (asynchronous). After release, the block stays IDLE until start.
